// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with flush, stall, bubble counting and optional load-use bubble insertion.
// Build with LOAD_USE_HAZARD_EN defined to enable load-use detection; otherwise LoadUseStall is tied low.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        Flush,
  input  logic        Stall,
  input  logic [3:0]  ID_ALUOp,
  input  logic [5:0]  ID_Funct,
  input  logic [4:0]  ID_Shamt,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Rd,
  input  logic [31:0] ID_RsData,
  input  logic [31:0] ID_RtData,
  input  logic [31:0] ID_Imm,
  input  logic [31:0] ID_PC,
  input  logic [7:0]  ID_Ctrl,
  output logic [3:0]  EX_ALUOp,
  output logic [5:0]  EX_Funct,
  output logic [4:0]  EX_Shamt,
  output logic [4:0]  EX_Rs,
  output logic [4:0]  EX_Rt,
  output logic [4:0]  EX_Rd,
  output logic [31:0] EX_RsData,
  output logic [31:0] EX_RtData,
  output logic [31:0] EX_Imm,
  output logic [31:0] EX_PC,
  output logic [7:0]  EX_Ctrl,
  output logic        LoadUseStall,
  output logic [15:0] BubbleCount
);
  logic [165:0] ex_d, ex_q, id_bus;
  logic [15:0]  bubble_count_d, bubble_count_q;
  logic         bubble;
  assign id_bus = {ID_ALUOp, ID_Funct, ID_Shamt, ID_Rs, ID_Rt, ID_Rd,
                   ID_RsData, ID_RtData, ID_Imm, ID_PC, ID_Ctrl};
  assign {EX_ALUOp, EX_Funct, EX_Shamt, EX_Rs, EX_Rt, EX_Rd,
          EX_RsData, EX_RtData, EX_Imm, EX_PC, EX_Ctrl} = ex_q;
  assign BubbleCount = bubble_count_q;
`ifdef LOAD_USE_HAZARD_EN
  assign LoadUseStall = EX_Ctrl[6] && EX_Rt != 5'd0 && (EX_Rt == ID_Rs || EX_Rt == ID_Rt);
`else
  assign LoadUseStall = 1'b0;
`endif
  // Flush squashes even a stalled stage; a load-use bubble only happens when the stage is free to move.
  always_comb begin
    bubble = Flush || (!Stall && LoadUseStall);
    ex_d = (reset || bubble) ? '0 : Stall ? ex_q : id_bus;
    bubble_count_d = reset ? 16'd0
                   : (bubble && bubble_count_q != 16'hFFFF) ? bubble_count_q + 16'd1
                   : bubble_count_q;
  end
  always_ff @(posedge clk) begin
    ex_q <= ex_d;
    bubble_count_q <= bubble_count_d;
  end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed self-checking bench for id_ex_reg against a behavioural model.
module tb_id_ex_reg;
`ifdef LOAD_USE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] aluop; logic [5:0] funct; logic [4:0] shamt;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd;
    logic [31:0] rsd; logic [31:0] rtd; logic [31:0] imm; logic [31:0] pc;
    logic [7:0] ctrl;
  } stage_t;
  logic clk = 0, reset = 1, Flush = 0, Stall = 0;
  stage_t id, ex_act, m_ex;
  logic [15:0] cnt_act, m_cnt;
  logic lus_act, en = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  id_ex_reg dut (
    .clk(clk), .reset(reset), .Flush(Flush), .Stall(Stall),
    .ID_ALUOp(id.aluop), .ID_Funct(id.funct), .ID_Shamt(id.shamt),
    .ID_Rs(id.rs), .ID_Rt(id.rt), .ID_Rd(id.rd),
    .ID_RsData(id.rsd), .ID_RtData(id.rtd), .ID_Imm(id.imm), .ID_PC(id.pc), .ID_Ctrl(id.ctrl),
    .EX_ALUOp(ex_act.aluop), .EX_Funct(ex_act.funct), .EX_Shamt(ex_act.shamt),
    .EX_Rs(ex_act.rs), .EX_Rt(ex_act.rt), .EX_Rd(ex_act.rd),
    .EX_RsData(ex_act.rsd), .EX_RtData(ex_act.rtd), .EX_Imm(ex_act.imm), .EX_PC(ex_act.pc),
    .EX_Ctrl(ex_act.ctrl), .LoadUseStall(lus_act), .BubbleCount(cnt_act)
  );
  function automatic bit hazard(stage_t ex, stage_t d);
    return HZ && ex.ctrl[6] && ex.rt != 0 && (ex.rt == d.rs || ex.rt == d.rt);
  endfunction
  task automatic chk(string name, logic [199:0] act, logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference: the specified priority reset > Flush > Stall > load-use > capture.
  always @(posedge clk) begin
    if (reset) begin
      m_ex <= '0; m_cnt <= 0;
    end else if (Flush || (!Stall && hazard(m_ex, id))) begin
      m_ex <= '0; m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
    end else if (!Stall) m_ex <= id;
  end
  always @(negedge clk) if (en) begin
    chk("ex_stage", 200'(ex_act), 200'(m_ex));
    chk("bubble_count", 200'(cnt_act), 200'(m_cnt));
    chk("load_use_stall", 200'(lus_act), 200'(hazard(m_ex, id)));
  end
  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic rand_id();
    id = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    id.rs = 5'($urandom_range(0, 3)); id.rt = 5'($urandom_range(0, 3));
    id.ctrl[6] = ($urandom_range(0, 1) == 1);
  endtask
  initial begin
    id = '0;
    reset = 1; cyc(2); en = 1;
    reset = 0;
    id.aluop = 4'b0011; id.funct = 6'h22; id.rsd = 5; id.rtd = 3;
    cyc();
    chk("lit_aluop", 200'(ex_act.aluop), 200'(4'b0011));
    chk("lit_funct", 200'(ex_act.funct), 200'(6'h22));
    chk("lit_rsdata", 200'(ex_act.rsd), 200'(32'd5));
    chk("lit_count0", 200'(cnt_act), 200'(16'd0));
    id = '0; id.ctrl = 8'h40; id.rt = 8; cyc();
    id = '0; id.rs = 8; id.rd = 3; #1;
    chk("lit_lus_same_cycle", 200'(lus_act), 200'(HZ));
    cyc();
    chk("lit_lus_ctrl", 200'(ex_act.ctrl), 200'(8'h00));
    chk("lit_lus_rs", 200'(ex_act.rs), 200'(HZ ? 5'd0 : 5'd8));
    chk("lit_lus_count", 200'(cnt_act), 200'(HZ ? 16'd1 : 16'd0));
    cyc();
    chk("lit_lus_capture", 200'(ex_act.rs), 200'(5'd8));
    chk("lit_lus_clear", 200'(lus_act), 200'(1'b0));
    reset = 1; cyc(); reset = 0;
    chk("lit_reset_lus", 200'(lus_act), 200'(1'b0));
    id = '0; id.ctrl = 8'h40; cyc();
    id = '0; #1;
    chk("lit_rt0_lus", 200'(lus_act), 200'(1'b0));
    cyc();
    chk("lit_rt0_count", 200'(cnt_act), 200'(16'd0));
    id.imm = 32'h1234; cyc();
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); cyc();
      chk("lit_stall_hold", 200'(ex_act.imm), 200'(32'h1234));
    end
    Flush = 1; cyc();
    chk("lit_stall_flush_ctrl", 200'(ex_act), 200'(0));
    chk("lit_stall_flush_count", 200'(cnt_act), 200'(16'd1));
    Stall = 0;
    for (int i = 0; i < 2000; i++) begin
      rand_id();
      Flush = ($urandom_range(0, 9) == 0);
      Stall = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 49) == 0);
      cyc();
    end
    reset = 1; Flush = 0; Stall = 0; cyc(); reset = 0;
    Flush = 1; cyc(65534);
    chk("lit_count_fffe", 200'(cnt_act), 200'(16'hFFFE));
    cyc(2);
    chk("lit_count_sat", 200'(cnt_act), 200'(16'hFFFF));
    cyc();
    chk("lit_count_held", 200'(cnt_act), 200'(16'hFFFF));
    Flush = 0; reset = 1; cyc(); reset = 0;
    chk("lit_count_reset", 200'(cnt_act), 200'(16'd0));
    en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
